// File: rtl/stream_pkg.sv
// Shared types and helpers for the stochastic-to-binary window counter.
package stream_pkg;

  // Top-level control states: waiting for START, or accumulating a window.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } win_state_t;

  // Width needed to hold the value WINDOW (a full window of ones).
  // Clamped to at least one bit so a degenerate parameter still elaborates.
  function automatic int calc_cnt_w(input int window);
    int w;
    if (window < 1) begin
      w = 1;
    end else begin
      w = $clog2(window + 1);
    end
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/win_counter.sv
// Paired sample / ones counters for one accumulation window.
// tc_o flags the CE-qualified sample that completes the window; on that
// edge both counters return to zero so the next window can start at once.
module win_counter
  import stream_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int CNT_W  = calc_cnt_w(WINDOW)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] ones_cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  logic [CNT_W-1:0] samp_cnt_q;
  logic [CNT_W-1:0] samp_cnt_d;
  logic [CNT_W-1:0] ones_cnt_q;
  logic [CNT_W-1:0] ones_cnt_d;
  logic [CNT_W-1:0] bit_ext_s;

  // Zero-extended incoming bit for the ones accumulator.
  always_comb begin
    bit_ext_s = CNT_W'(bit_i);
  end

  // Terminal count: the enabled sample that is the last one of the window.
  always_comb begin
    tc_o = en_i && (samp_cnt_q == CNT_LAST);
  end

  // Next counter values: clear, wrap on terminal count, advance, or hold.
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    ones_cnt_d = ones_cnt_q;
    if (clr_i) begin
      samp_cnt_d = CNT_ZERO;
      ones_cnt_d = CNT_ZERO;
    end else if (tc_o) begin
      samp_cnt_d = CNT_ZERO;
      ones_cnt_d = CNT_ZERO;
    end else if (en_i) begin
      samp_cnt_d = samp_cnt_q + CNT_ONE;
      ones_cnt_d = ones_cnt_q + bit_ext_s;
    end else begin
      samp_cnt_d = samp_cnt_q;
      ones_cnt_d = ones_cnt_q;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      samp_cnt_q <= CNT_ZERO;
      ones_cnt_q <= CNT_ZERO;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  // The partial ones count feeds the result adder in the parent.
  always_comb begin
    ones_cnt_o = ones_cnt_q;
  end

endmodule

// File: rtl/stream_window_counter.sv
// Stochastic-to-binary converter: counts the 1s in a window of CE-qualified
// samples of an upstream bitstream and holds the count under a valid/ack
// handshake with a sticky overrun flag. Supports one-shot and back-to-back
// (CONT) windows.
module stream_window_counter
  import stream_pkg::*;
#(
  parameter int WINDOW = 256,
  parameter int CNT_W  = calc_cnt_w(WINDOW)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             IN_BIT,
  input  logic             START,
  input  logic             CONT,
  input  logic             RESULT_ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] RESULT,
  output logic             RESULT_VALID,
  output logic             OVERRUN
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);

  win_state_t       state_q;
  win_state_t       state_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic [CNT_W-1:0] result_q;
  logic [CNT_W-1:0] result_d;
  logic             valid_q;
  logic             valid_d;
  logic             overrun_q;
  logic             overrun_d;

  logic             clr_s;
  logic             en_s;
  logic             tc_s;
  logic [CNT_W-1:0] ones_cnt_s;
  logic [CNT_W-1:0] new_result_s;

  // Counters are held clear while idle, so accepting START leaves them at
  // zero and the sample on the START edge itself is never counted.
  always_comb begin
    clr_s = (state_q == IDLE);
    en_s  = (state_q == ACCUM) && CE;
  end

  win_counter #(
    .WINDOW (WINDOW),
    .CNT_W  (CNT_W)
  ) u_win_counter (
    .clk_i      (CLK),
    .reset_i    (RESET),
    .clr_i      (clr_s),
    .en_i       (en_s),
    .bit_i      (IN_BIT),
    .ones_cnt_o (ones_cnt_s),
    .tc_o       (tc_s)
  );

  // Final count includes the bit sampled on the completing edge; it is at
  // most WINDOW, which CNT_W always holds.
  always_comb begin
    new_result_s = ones_cnt_s + CNT_W'(IN_BIT);
  end

  // Next-state for the control FSM, result register and handshake flags.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (tc_s) begin
          if (CONT) begin
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == ACCUM);

    // A completion always wins over an acknowledge on the same edge: the
    // fresh result is loaded and stays valid. Overrun only when the old
    // result is lost without having been acknowledged.
    if (tc_s) begin
      result_d = new_result_s;
      done_d   = 1'b1;
      valid_d  = 1'b1;
      if (valid_q && !RESULT_ACK) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (RESULT_ACK) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // FSM and registered outputs; reset overrides every other input.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= CNT_ZERO;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Drive ports straight from the registers.
  always_comb begin
    BUSY         = busy_q;
    DONE         = done_q;
    RESULT       = result_q;
    RESULT_VALID = valid_q;
    OVERRUN      = overrun_q;
  end

endmodule

// File: tb/tb_stream_window_counter.sv
// Directed bench for stream_window_counter: a WINDOW=16 instance for the
// main scenarios and a WINDOW=1 instance for the single-sample boundary.
module tb_stream_window_counter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET;
  logic CE;
  logic in_bit_drv;
  logic START;
  logic CONT;
  logic RESULT_ACK;
  logic BUSY;
  logic DONE;
  logic [4:0] RESULT;
  logic RESULT_VALID;
  logic OVERRUN;

  logic start1;
  logic cont1;
  logic ack1;
  logic busy1;
  logic done1;
  logic [0:0] result1;
  logic valid1;
  logic overrun1;

  // Behavioural stand-in for the upstream registered XOR gate.
  logic use_xor;
  logic in_a;
  logic in_b;
  logic xor_q = 1'b0;
  logic in_bit_s;

  always @(posedge CLK) begin
    if (CE) xor_q <= in_a ^ in_b;
  end

  assign in_bit_s = use_xor ? xor_q : in_bit_drv;

  int tests = 0;
  int fails = 0;

  stream_window_counter #(.WINDOW(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CE           (CE),
    .IN_BIT       (in_bit_s),
    .START        (START),
    .CONT         (CONT),
    .RESULT_ACK   (RESULT_ACK),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .RESULT       (RESULT),
    .RESULT_VALID (RESULT_VALID),
    .OVERRUN      (OVERRUN)
  );

  stream_window_counter #(.WINDOW(1)) dut1 (
    .CLK          (CLK),
    .RESET        (RESET),
    .CE           (CE),
    .IN_BIT       (in_bit_s),
    .START        (start1),
    .CONT         (cont1),
    .RESULT_ACK   (ack1),
    .BUSY         (busy1),
    .DONE         (done1),
    .RESULT       (result1),
    .RESULT_VALID (valid1),
    .OVERRUN      (overrun1)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b0; in_bit_drv = 1'b0; START = 1'b0; CONT = 1'b0;
    RESULT_ACK = 1'b0; start1 = 1'b0; cont1 = 1'b0; ack1 = 1'b0;
    use_xor = 1'b0; in_a = 1'b0; in_b = 1'b0;

    // Reset held 3 cycles with random other inputs.
    for (int i = 0; i < 3; i++) begin
      CE         = 1'($urandom_range(0, 1));
      in_bit_drv = 1'($urandom_range(0, 1));
      START      = 1'($urandom_range(0, 1));
      CONT       = 1'($urandom_range(0, 1));
      RESULT_ACK = 1'($urandom_range(0, 1));
      start1     = 1'($urandom_range(0, 1));
      step();
      chk("reset_outs", {BUSY, DONE, RESULT, RESULT_VALID, OVERRUN}, 32'd0);
      chk("reset_outs_w1", {busy1, done1, result1, valid1, overrun1}, 32'd0);
    end
    RESET = 1'b0; CE = 1'b0; in_bit_drv = 1'b0; START = 1'b0; CONT = 1'b0;
    RESULT_ACK = 1'b0; start1 = 1'b0;
    step();
    chk("post_reset_busy", BUSY, 32'd0);
    chk("post_reset_valid", RESULT_VALID, 32'd0);

    // One-shot window, all ones, CE continuous.
    CE = 1'b1; in_bit_drv = 1'b1; START = 1'b1;
    step();
    chk("start_busy", BUSY, 32'd1);
    START = 1'b0;
    repeat (15) step();
    chk("ones_pre_done", DONE, 32'd0);
    chk("ones_pre_valid", RESULT_VALID, 32'd0);
    step();
    chk("ones_done", DONE, 32'd1);
    chk("ones_result", RESULT, 32'd16);
    chk("ones_valid", RESULT_VALID, 32'd1);
    chk("ones_busy_off", BUSY, 32'd0);
    RESULT_ACK = 1'b1;
    step();
    chk("ack_valid_clr", RESULT_VALID, 32'd0);
    chk("ack_done_clr", DONE, 32'd0);
    RESULT_ACK = 1'b0;

    // CE toggling, ones only while CE=0 -> 32 cycles, result 0.
    CE = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 32; i++) begin
      CE = (i % 2 == 1);
      in_bit_drv = ~CE;
      step();
      if (i == 30) chk("toggle_not_yet", DONE, 32'd0);
    end
    chk("toggle0_done", DONE, 32'd1);
    chk("toggle0_result", RESULT, 32'd0);
    chk("toggle0_valid", RESULT_VALID, 32'd1);
    RESULT_ACK = 1'b1; CE = 1'b1;
    step();
    RESULT_ACK = 1'b0;

    // CE toggling, ones only while CE=1 -> result 16.
    CE = 1'b0; START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 32; i++) begin
      CE = (i % 2 == 1);
      in_bit_drv = CE;
      step();
    end
    chk("toggle1_done", DONE, 32'd1);
    chk("toggle1_result", RESULT, 32'd16);
    chk("toggle1_overrun", OVERRUN, 32'd0);
    RESULT_ACK = 1'b1;
    step();
    RESULT_ACK = 1'b0;

    // Continuous windows fed by the XOR model (1 xor 0), no ack.
    use_xor = 1'b1; in_a = 1'b1; in_b = 1'b0; CE = 1'b1;
    step();
    CONT = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("cont_busy_w1", BUSY, 32'd1);
    end
    chk("cont_w1_done", DONE, 32'd1);
    chk("cont_w1_result", RESULT, 32'd16);
    chk("cont_w1_overrun", OVERRUN, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("cont_busy_w2", BUSY, 32'd1);
    end
    chk("cont_w2_done", DONE, 32'd1);
    chk("cont_w2_result", RESULT, 32'd16);
    chk("cont_w2_overrun", OVERRUN, 32'd1);
    CONT = 1'b0; use_xor = 1'b0; RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_overrun_clr", OVERRUN, 32'd0);
    chk("rst_result_clr", RESULT, 32'd0);

    // Reset after 8 of 16 samples discards the partial count.
    in_bit_drv = 1'b1; CE = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    repeat (8) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("abort_busy", BUSY, 32'd0);
    chk("abort_result", RESULT, 32'd0);
    chk("abort_valid", RESULT_VALID, 32'd0);
    step();
    chk("abort_idle", BUSY, 32'd0);
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (16) step();
    chk("restart_result", RESULT, 32'd16);
    chk("restart_done", DONE, 32'd1);
    RESULT_ACK = 1'b1;
    step();
    RESULT_ACK = 1'b0;

    // Ack on the completion edge of the second continuous window.
    CONT = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    repeat (16) step();
    chk("ackc_w1_valid", RESULT_VALID, 32'd1);
    chk("ackc_w1_overrun", OVERRUN, 32'd0);
    repeat (15) step();
    RESULT_ACK = 1'b1;
    step();
    RESULT_ACK = 1'b0; CONT = 1'b0;
    chk("ackc_w2_done", DONE, 32'd1);
    chk("ackc_w2_valid", RESULT_VALID, 32'd1);
    chk("ackc_w2_overrun", OVERRUN, 32'd0);
    chk("ackc_w2_result", RESULT, 32'd16);
    repeat (16) step();
    chk("ackc_w3_overrun", OVERRUN, 32'd1);
    chk("ackc_w3_idle", BUSY, 32'd0);
    RESULT_ACK = 1'b1;
    step();
    chk("late_ack_valid", RESULT_VALID, 32'd0);
    step();
    chk("idle_ack_valid", RESULT_VALID, 32'd0);
    chk("idle_ack_overrun", OVERRUN, 32'd1);
    RESULT_ACK = 1'b0;

    // WINDOW=1 boundary: every enabled sample completes a window.
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    CE = 1'b1; in_bit_drv = 1'b1; start1 = 1'b1; cont1 = 1'b1;
    step();
    chk("w1_busy", busy1, 32'd1);
    chk("w1_no_done_on_start", done1, 32'd0);
    start1 = 1'b0;
    step();
    chk("w1_done_a", done1, 32'd1);
    chk("w1_result_a", result1, 32'd1);
    chk("w1_valid_a", valid1, 32'd1);
    in_bit_drv = 1'b0;
    step();
    chk("w1_result_b", result1, 32'd0);
    chk("w1_overrun_b", overrun1, 32'd1);
    ack1 = 1'b1; in_bit_drv = 1'b1;
    step();
    chk("w1_result_c", result1, 32'd1);
    chk("w1_valid_c", valid1, 32'd1);
    CE = 1'b0; ack1 = 1'b0;
    step();
    chk("w1_ce_off_done", done1, 32'd0);
    chk("w1_main_idle", BUSY, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
